pc_exception_unit: RTL and testbench

PC_EXCEPTION_UNIT -- requirements
Module: pc_exception_unit

---
 rtl/pc_exception_unit.sv | 76 +++++++
 tb/tb_pc_exception_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pc_exception_unit.sv
// pc_exception_unit: PC register with exception capture and vectored restart.
// Optional alignment trap on PC loads when PC_ALIGN_CHECK_EN is defined.
module pc_exception_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EPC_OFFSET = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        branch_ne,
    input  logic        zero,
    input  logic [2:0]  exc_req,
    input  logic [7:0]  mem_data_in,
    output logic [31:0] pc_out,
    output logic [31:0] epc_out,
    output logic        exc_busy,
    output logic        exc_mem_read,
    output logic [31:0] exc_mem_addr,
    output logic [1:0]  exc_cause
);
    typedef enum logic [1:0] {IDLE, VEC_READ, VEC_WAIT, VEC_LOAD} state_t;
    state_t      state;
    logic        take;
    logic        exc;
    logic [1:0]  cause;
    logic [31:0] vec;
    assign take  = pc_write | (pc_write_cond & (zero ^ branch_ne));
`ifdef PC_ALIGN_CHECK_EN
    assign exc   = (|exc_req) | (take & (|pc_next[1:0]));
`else
    assign exc   = |exc_req;
`endif
    assign cause = exc_req[2] ? 2'd3 : exc_req[1] ? 2'd2 : exc_req[0] ? 2'd1 : 2'd0;
    // Cause 0 only reaches the vector mux via the alignment trap.
    assign vec   = cause == 2'd3 ? 32'd253 : cause == 2'd2 ? 32'd254 :
                   cause == 2'd1 ? 32'd255 : 32'd252;
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pc_out       <= RESET_PC;
            epc_out      <= 32'd0;
            exc_cause    <= 2'd0;
            exc_busy     <= 1'b0;
            exc_mem_read <= 1'b0;
            exc_mem_addr <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (exc) begin
                        epc_out      <= pc_out - EPC_OFFSET;
                        exc_cause    <= cause;
                        exc_busy     <= 1'b1;
                        exc_mem_read <= 1'b1;
                        exc_mem_addr <= vec;
                        state        <= VEC_READ;
                    end else if (take) begin
                        pc_out <= pc_next;
                    end
                end
                VEC_READ: begin
                    exc_mem_read <= 1'b0;
                    exc_mem_addr <= 32'd0;
                    state        <= VEC_WAIT;
                end
                VEC_WAIT: state <= VEC_LOAD;
                VEC_LOAD: begin
                    pc_out   <= {24'b0, mem_data_in};
                    exc_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_exception_unit.sv
// tb_pc_exception_unit: directed and randomized checks of pc_exception_unit
// against a countdown-based reference model.
module tb_pc_exception_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset, pc_write, pc_write_cond, branch_ne, zero;
    logic [2:0]  exc_req;
    logic [31:0] pc_next;
    logic [7:0]  mem_data_in;
    logic [31:0] pc_out, epc_out, exc_mem_addr;
    logic        exc_busy, exc_mem_read;
    logic [1:0]  exc_cause;
    int n_vec = 0;
    int n_bad = 0;
    int          m_left;
    logic [31:0] m_pc, m_epc, m_addr;
    logic [1:0]  m_cause;
    logic        m_rd;
    pc_exception_unit #(.RESET_PC(RESET_PC), .EPC_OFFSET(32'd4)) dut (
        .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .zero(zero),
        .exc_req(exc_req), .mem_data_in(mem_data_in), .pc_out(pc_out),
        .epc_out(epc_out), .exc_busy(exc_busy), .exc_mem_read(exc_mem_read),
        .exc_mem_addr(exc_mem_addr), .exc_cause(exc_cause)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask
    // m_left counts edges still to go before the vector is loaded.
    task automatic model_edge();
        int vtab[4] = '{252, 255, 254, 253};
        bit taken, bad;
        if (reset) begin
            m_pc = RESET_PC; m_epc = 0; m_cause = 0; m_rd = 0; m_addr = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            m_rd = 0;
            m_addr = 0;
            if (m_left == 0) m_pc = {24'b0, mem_data_in};
        end else begin
            taken = pc_write || (pc_write_cond && (zero != branch_ne));
            bad = ALIGN && taken && (pc_next[1:0] != 2'b00);
            if (exc_req != 0 || bad) begin
                m_epc = m_pc - 32'd4;
                m_cause = exc_req[2] ? 2'd3 : exc_req[1] ? 2'd2 : exc_req[0] ? 2'd1 : 2'd0;
                m_rd = 1;
                m_addr = vtab[m_cause];
                m_left = 3;
            end else if (taken) begin
                m_pc = pc_next;
            end
        end
    endtask
    task automatic cycle(input logic r, input logic pw, input logic pwc, input logic bne,
                         input logic z, input logic [2:0] ex, input logic [31:0] nx,
                         input logic [7:0] md);
        @(negedge clk);
        reset = r; pc_write = pw; pc_write_cond = pwc; branch_ne = bne; zero = z;
        exc_req = ex; pc_next = nx; mem_data_in = md;
        @(posedge clk);
        model_edge();
        #1;
        chk("pc", pc_out, m_pc);
        chk("epc", epc_out, m_epc);
        chk("busy", {31'b0, exc_busy}, {31'b0, m_left > 0});
        chk("mem_read", {31'b0, exc_mem_read}, {31'b0, m_rd});
        chk("mem_addr", exc_mem_addr, m_addr);
        chk("cause", {30'b0, exc_cause}, {30'b0, m_cause});
    endtask
    task automatic idle(input logic [7:0] md);
        cycle(0, 0, 0, 0, 0, 3'b000, 32'h0, md);
    endtask
    initial begin
        m_pc = 0; m_epc = 0; m_cause = 0; m_rd = 0; m_addr = 0; m_left = 0;
        reset = 1; pc_write = 0; pc_write_cond = 0; branch_ne = 0; zero = 0;
        exc_req = 0; pc_next = 0; mem_data_in = 0;
        cycle(1, 0, 0, 0, 0, 3'b000, 32'h0, 8'h00);
        chk("reset_pc", pc_out, RESET_PC);
        cycle(0, 1, 0, 0, 0, 3'b000, 32'h10, 8'h00);
        chk("load_10", pc_out, 32'h10);
        chk("load_epc0", epc_out, 32'h0);
        cycle(0, 0, 1, 0, 0, 3'b000, 32'h40, 8'h00);
        chk("beq_nt", pc_out, 32'h10);
        cycle(0, 0, 1, 0, 1, 3'b000, 32'h40, 8'h00);
        chk("beq_t", pc_out, 32'h40);
        cycle(0, 0, 1, 1, 1, 3'b000, 32'h80, 8'h00);
        chk("bne_nt", pc_out, 32'h40);
        cycle(0, 0, 1, 1, 0, 3'b000, 32'h80, 8'h00);
        chk("bne_t", pc_out, 32'h80);
        cycle(0, 1, 0, 0, 0, 3'b000, 32'h20, 8'h00);
        cycle(0, 0, 0, 0, 0, 3'b110, 32'h0, 8'h8A);
        chk("epc_1c", epc_out, 32'h1C);
        chk("cause_3", {30'b0, exc_cause}, 32'd3);
        chk("vec_253", exc_mem_addr, 32'd253);
        chk("pc_hold", pc_out, 32'h20);
        idle(8'h8A);
        idle(8'h8A);
        idle(8'h8A);
        chk("vec_load", pc_out, 32'h8A);
        chk("busy_low", {31'b0, exc_busy}, 32'd0);
        cycle(0, 1, 0, 0, 0, 3'b001, 32'h300, 8'h55);
        chk("exc_wins", pc_out, 32'h8A);
        chk("cause_1", {30'b0, exc_cause}, 32'd1);
        chk("vec_255", exc_mem_addr, 32'd255);
        cycle(0, 1, 0, 0, 0, 3'b100, 32'h400, 8'h55);
        cycle(0, 1, 1, 0, 1, 3'b010, 32'h500, 8'h55);
        chk("busy_ignore", pc_out, 32'h8A);
        chk("no_nest", {30'b0, exc_cause}, 32'd1);
        idle(8'h55);
        chk("vec_55", pc_out, 32'h55);
        cycle(0, 0, 0, 0, 0, 3'b010, 32'h0, 8'h77);
        idle(8'h77);
        cycle(1, 0, 0, 0, 0, 3'b000, 32'h0, 8'h77);
        chk("rst_wait_pc", pc_out, RESET_PC);
        chk("rst_wait_epc", epc_out, 32'h0);
        chk("rst_wait_busy", {31'b0, exc_busy}, 32'd0);
        idle(8'h77);
        idle(8'h77);
        chk("no_vec_load", pc_out, RESET_PC);
        cycle(0, 0, 0, 0, 0, 3'b010, 32'h0, 8'h00);
        chk("epc_wrap", epc_out, 32'hFFFF_FFFC);
        chk("cause_2", {30'b0, exc_cause}, 32'd2);
        chk("vec_254", exc_mem_addr, 32'd254);
        idle(8'h00);
        idle(8'h00);
        idle(8'h00);
        cycle(0, 1, 0, 0, 0, 3'b000, 32'h42, 8'h33);
        if (ALIGN) begin
            chk("align_vec", exc_mem_addr, 32'd252);
            chk("align_hold", pc_out, 32'h0);
        end else begin
            chk("unaligned_load", pc_out, 32'h42);
        end
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] nx;
            nx = $urandom;
            if ($urandom_range(0, 3) != 0) nx[1:0] = 2'b00;
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  1'($urandom), 1'($urandom),
                  $urandom_range(0, 5) == 0 ? 3'($urandom) : 3'b000, nx, 8'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
